spi_slave_if: RTL and testbench

SPI responder for the SPI link, the far end of the SPI master that drives `SPI_sclk`/`SPI_csn`/`SPI_mosi` and samples `SPI_miso`. It oversamples the SPI pins in the system clock domain and deserialises MOSI bytes to a parallel strobe. It also serialises bytes from a one-deep transmit buffer onto MISO. It sits on the peripheral side of the link and is fed by local logic through a valid/ready transmit handshake.

---
 rtl/spi_slave_if.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_if.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: deserialises MOSI bytes to rx_data/rx_valid and serialises a
// one-deep transmit buffer onto MISO, with all SPI pins oversampled on clk.
module spi_slave_if #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       frame_err,
   input  logic       SPI_sclk,
   input  logic       SPI_csn,
   input  logic       SPI_mosi,
   output logic       SPI_miso,
   output logic       SPI_miso_oe
);
   // state  | meaning
   // IDLE   | CSN high (or not yet re-armed); sclk/mosi ignored
   // ACTIVE | frame in progress; sampling on sclk rise, shifting on sclk fall
   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] vld_q, vld_d;
   logic                   sclk_dly_q, sclk_dly_d;
   logic                   csn_dly_q, csn_dly_d;
   logic                   armed_q, armed_d;
   logic [7:0]             rx_sh_q, rx_sh_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic [7:0]             tx_sh_q, tx_sh_d;
   logic [7:0]             buf_q, buf_d;
   logic                   buf_full_q, buf_full_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   tx_underrun_q, tx_underrun_d;
   logic                   frame_err_q, frame_err_d;
   logic                   miso_q, miso_d;

   logic sclk_s, csn_s, mosi_s;
   logic sclk_rise, sclk_fall, csn_rise, csn_fall;
   logic load;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign csn_s  = csn_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign csn_rise  = csn_s & ~csn_dly_q;
   // A fall only counts once a real high has been seen after reset, so a CSN
   // that was already low when reset released cannot start a frame.
   assign csn_fall  = armed_q & ~csn_s & csn_dly_q;

   always_comb begin
      sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], SPI_sclk};
      csn_sync_d    = {csn_sync_q[SYNC_STAGES-2:0], SPI_csn};
      mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], SPI_mosi};
      vld_d         = {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_d    = sclk_s;
      csn_dly_d     = csn_s;
      armed_d       = armed_q | (vld_q[SYNC_STAGES-1] & csn_s);
      state_d       = state_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_sh_d       = tx_sh_q;
      buf_d         = buf_q;
      buf_full_d    = buf_full_q;
      bit_cnt_d     = bit_cnt_q;
      tx_underrun_d = 1'b0;
      frame_err_d   = 1'b0;
      miso_d        = tx_sh_q[7];
      load          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (csn_fall) begin
               state_d   = ST_ACTIVE;
               bit_cnt_d = 3'd0;
               load      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (csn_rise) begin
               state_d     = ST_IDLE;
               frame_err_d = (bit_cnt_q != 3'd0);
               bit_cnt_d   = 3'd0;
            end else if (sclk_rise) begin
               rx_sh_d   = {rx_sh_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d  = {rx_sh_q[6:0], mosi_s};
                  rx_valid_d = 1'b1;
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q != 3'd0) tx_sh_d = {tx_sh_q[6:0], 1'b0};
               else                   load    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         if (buf_full_q) begin
            tx_sh_d    = buf_q;
            buf_full_d = 1'b0;
         end else begin
            tx_sh_d       = IDLE_BYTE;
            tx_underrun_d = 1'b1;
         end
      end
      // Acceptance is gated by the pre-load fullness, so a byte taken in a load
      // cycle always lands in the buffer for the following byte slot.
      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sclk_sync_q   <= '0;
         csn_sync_q    <= '1;
         mosi_sync_q   <= '0;
         vld_q         <= '0;
         sclk_dly_q    <= 1'b0;
         csn_dly_q     <= 1'b1;
         armed_q       <= 1'b0;
         rx_sh_q       <= 8'h00;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         tx_sh_q       <= 8'h00;
         buf_q         <= 8'h00;
         buf_full_q    <= 1'b0;
         bit_cnt_q     <= 3'd0;
         tx_underrun_q <= 1'b0;
         frame_err_q   <= 1'b0;
         miso_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         sclk_sync_q   <= sclk_sync_d;
         csn_sync_q    <= csn_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         vld_q         <= vld_d;
         sclk_dly_q    <= sclk_dly_d;
         csn_dly_q     <= csn_dly_d;
         armed_q       <= armed_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_sh_q       <= tx_sh_d;
         buf_q         <= buf_d;
         buf_full_q    <= buf_full_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_underrun_q <= tx_underrun_d;
         frame_err_q   <= frame_err_d;
         miso_q        <= miso_d;
      end
   end

   assign tx_ready    = ~buf_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = tx_underrun_q;
   assign frame_err   = frame_err_q;
   assign SPI_miso    = miso_q;
   assign SPI_miso_oe = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a bit-level SPI master with a byte-level buffer model
// predicting MISO bytes, received bytes, underruns and framing errors.
module tb_spi_slave_if;
   localparam int SYNC = 2;
   localparam logic [7:0] IDLE_B = 8'h00;
   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       frame_err;
   logic       SPI_sclk = 1'b0;
   logic       SPI_csn = 1'b1;
   logic       SPI_mosi = 1'b0;
   logic       SPI_miso;
   logic       SPI_miso_oe;

   spi_slave_if #(.SYNC_STAGES(SYNC), .IDLE_BYTE(IDLE_B)) dut (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_underrun(tx_underrun), .frame_err(frame_err),
      .SPI_sclk(SPI_sclk), .SPI_csn(SPI_csn), .SPI_mosi(SPI_mosi),
      .SPI_miso(SPI_miso), .SPI_miso_oe(SPI_miso_oe)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int under_cnt = 0;
   int ferr_cnt = 0;
   logic [7:0] rx_q[$];
   int rxv_cyc[$];
   int rise_cyc[$];

   // Byte-level reference: one buffer slot, loads at frame start and byte boundaries.
   logic       m_full = 1'b0;
   logic [7:0] m_buf = 8'h00;
   int         exp_un = 0;
   logic [7:0] mosi_bytes[8];
   logic [7:0] exp_miso[8];
   logic [7:0] got_miso[8];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            rx_q.push_back(rx_data);
            rxv_cyc.push_back(cyc);
         end
         if (tx_underrun) under_cnt++;
         if (frame_err) ferr_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_load(input int idx);
      if (m_full) begin
         exp_miso[idx] = m_buf;
         m_full = 1'b0;
      end else begin
         exp_miso[idx] = IDLE_B;
         exp_un++;
      end
   endtask

   task automatic push_byte(input logic [7:0] v);
      chk("tx_ready_before_push", 32'(tx_ready), 32'(!m_full));
      if (!m_full) begin
         tx_data  = v;
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         m_buf    = v;
         m_full   = 1'b1;
         @(negedge clk);
         chk("tx_ready_after_push", 32'(tx_ready), 32'd0);
      end else begin
         wait_cyc(2);
      end
   endtask

   // Frames end with CSN rising while sclk is still high, so no trailing reload.
   task automatic do_frame(input int nbytes, input int tail, input int push_b,
                           input int push_i, input logic [7:0] push_v);
      int nb_total, nbits, rx0, rs0, un0, fe0;
      logic last;
      rx0 = rx_q.size(); rs0 = rise_cyc.size();
      un0 = under_cnt; fe0 = ferr_cnt; exp_un = 0;
      nb_total = nbytes + ((tail > 0) ? 1 : 0);
      @(negedge clk);
      SPI_csn  = 1'b0;
      SPI_mosi = mosi_bytes[0][7];
      model_load(0);
      wait_cyc(HALF);
      chk("oe_active", 32'(SPI_miso_oe), 32'd1);
      chk("tx_ready_after_load", 32'(tx_ready), 32'(!m_full));
      for (int b = 0; b < nb_total; b++) begin
         nbits = (b < nbytes) ? 8 : tail;
         for (int i = 0; i < nbits; i++) begin
            got_miso[b][7-i] = SPI_miso;
            SPI_sclk = 1'b1;
            if (i == 7) rise_cyc.push_back(cyc);
            if (b == push_b && i == push_i) begin
               push_byte(push_v);
               wait_cyc(HALF - 2);
            end else begin
               wait_cyc(HALF);
            end
            last = (b == nb_total - 1) && (i == nbits - 1);
            if (!last) begin
               SPI_sclk = 1'b0;
               if (i == nbits - 1) begin
                  SPI_mosi = mosi_bytes[b+1][7];
                  model_load(b + 1);
               end else begin
                  SPI_mosi = mosi_bytes[b][6-i];
               end
               wait_cyc(HALF);
            end
         end
      end
      SPI_csn = 1'b1;
      wait_cyc(5);
      SPI_sclk = 1'b0;
      SPI_mosi = 1'b0;
      wait_cyc(8);
      chk("rx_count", 32'(rx_q.size() - rx0), 32'(nbytes));
      if (rx_q.size() - rx0 == nbytes) begin
         for (int k = 0; k < nbytes; k++) begin
            chk("rx_data", 32'(rx_q[rx0+k]), 32'(mosi_bytes[k]));
            chk("rx_latency", 32'(rxv_cyc[rx0+k] - rise_cyc[rs0+k]), 32'(SYNC + 1));
         end
      end
      for (int k = 0; k < nbytes; k++) chk("miso_byte", 32'(got_miso[k]), 32'(exp_miso[k]));
      chk("underruns", 32'(under_cnt - un0), 32'(exp_un));
      chk("frame_err", 32'(ferr_cnt - fe0), 32'(tail > 0));
      chk("oe_idle", 32'(SPI_miso_oe), 32'd0);
      chk("tx_ready_end", 32'(tx_ready), 32'(!m_full));
   endtask

   task automatic chk_reset_vals();
      chk("rst_miso", 32'(SPI_miso), 32'd0);
      chk("rst_oe", 32'(SPI_miso_oe), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_rx_data", 32'(rx_data), 32'h00);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_underrun", 32'(tx_underrun), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
   endtask

   initial begin
      int rx0, un0, fe0, nb, tl, pb, pi;
      logic rdy0;
      wait_cyc(4);
      chk_reset_vals();
      rst = 1'b0;
      wait_cyc(10);

      // Preloaded byte on a single-byte frame.
      mosi_bytes[0] = 8'h3C;
      push_byte(8'hA5);
      do_frame(1, 0, -1, 0, 8'h00);

      // Three bytes: 0x11 preloaded, 0x22 handed over during the first byte.
      mosi_bytes[0] = 8'hDE; mosi_bytes[1] = 8'hAD; mosi_bytes[2] = 8'hBE;
      push_byte(8'h11);
      do_frame(3, 0, 0, 3, 8'h22);

      // Empty buffer.
      mosi_bytes[0] = 8'h96;
      do_frame(1, 0, -1, 0, 8'h00);

      // Partial byte then a clean frame.
      mosi_bytes[0] = 8'hF3;
      do_frame(0, 5, -1, 0, 8'h00);
      mosi_bytes[0] = 8'h5A;
      do_frame(1, 0, -1, 0, 8'h00);

      // sclk activity with CSN high.
      rx0 = rx_q.size(); un0 = under_cnt; fe0 = ferr_cnt; rdy0 = tx_ready;
      for (int i = 0; i < 6; i++) begin
         SPI_sclk = 1'b1; SPI_mosi = ~SPI_mosi;
         wait_cyc(HALF);
         chk("idle_oe", 32'(SPI_miso_oe), 32'd0);
         SPI_sclk = 1'b0;
         wait_cyc(HALF);
      end
      wait_cyc(6);
      chk("idle_rx_count", 32'(rx_q.size() - rx0), 32'd0);
      chk("idle_underruns", 32'(under_cnt - un0), 32'd0);
      chk("idle_frame_err", 32'(ferr_cnt - fe0), 32'd0);
      chk("idle_tx_ready", 32'(tx_ready), 32'(rdy0));

      // Reset in the middle of a byte with 0x77 buffered, CSN held low afterwards.
      @(negedge clk);
      SPI_csn = 1'b0; SPI_mosi = 1'b1;
      model_load(0);
      wait_cyc(HALF);
      for (int i = 0; i < 4; i++) begin
         SPI_sclk = 1'b1;
         if (i == 1) begin
            push_byte(8'h77);
            wait_cyc(HALF - 2);
         end else begin
            wait_cyc(HALF);
         end
         SPI_sclk = 1'b0; SPI_mosi = 1'($urandom);
         wait_cyc(HALF);
      end
      rst = 1'b1;
      wait_cyc(2);
      chk_reset_vals();
      rst = 1'b0;
      m_full = 1'b0;
      rx0 = rx_q.size(); un0 = under_cnt; fe0 = ferr_cnt;
      for (int i = 0; i < 10; i++) begin
         SPI_sclk = 1'b1; SPI_mosi = 1'($urandom);
         wait_cyc(HALF);
         chk("held_csn_oe", 32'(SPI_miso_oe), 32'd0);
         SPI_sclk = 1'b0;
         wait_cyc(HALF);
      end
      chk("held_csn_rx", 32'(rx_q.size() - rx0), 32'd0);
      chk("held_csn_underrun", 32'(under_cnt - un0), 32'd0);
      chk("held_csn_frame_err", 32'(ferr_cnt - fe0), 32'd0);
      chk("held_csn_tx_ready", 32'(tx_ready), 32'd1);
      SPI_csn = 1'b1;
      wait_cyc(10);
      mosi_bytes[0] = 8'hC7;
      do_frame(1, 0, -1, 0, 8'h00);

      // Randomised frames against the buffer model.
      for (int n = 0; n < 8; n++) begin
         nb = int'($urandom_range(1, 3));
         tl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         for (int k = 0; k < 8; k++) mosi_bytes[k] = 8'($urandom);
         if ($urandom_range(0, 1) == 1) push_byte(8'($urandom));
         pb = int'($urandom_range(0, nb - 1));
         pi = int'($urandom_range(0, 7));
         do_frame(nb, tl, pb, pi, 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
